// File: rtl/statseg_pkg.sv
// Shared types and default sizing for the static-segment controller.
package statseg_pkg;

    localparam int                    DEF_ADDR_W    = 20;
    localparam int                    DEF_DATA_W    = 20;
    localparam int                    DEF_OFF_W     = 8;
    localparam logic [DEF_ADDR_W-1:0] DEF_SEG_START = 20'h80000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/statseg_ctrl_if.sv
// Loader/decoder, lookup, memory-write and statseg signals of statseg_ctrl.
interface statseg_ctrl_if
    import statseg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OFF_W  = DEF_OFF_W
) ();
    logic              prog_start;
    logic              decl_valid;
    logic              decl_ready;
    logic [DATA_W-1:0] decl_data;
    logic              lkup_valid;
    logic              lkup_ready;
    logic [OFF_W-1:0]  lkup_off;
    logic [ADDR_W-1:0] lkup_addr;
    logic              lkup_done;
    logic              err_oob;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;
    logic              seg_load;
    logic [ADDR_W-1:0] seg_addr;
    logic [ADDR_W-1:0] seg_base;
    logic [OFF_W:0]    const_count;
    logic              full;

    modport slave (
        input  prog_start, decl_valid, decl_data, lkup_valid, lkup_off, mem_wr_ack, seg_base,
        output decl_ready, lkup_ready, lkup_addr, lkup_done, err_oob,
               mem_wr_en, mem_wr_addr, mem_wr_data, seg_load, seg_addr, const_count, full
    );

    modport master (
        output prog_start, decl_valid, decl_data, lkup_valid, lkup_off, mem_wr_ack, seg_base,
        input  decl_ready, lkup_ready, lkup_addr, lkup_done, err_oob,
               mem_wr_en, mem_wr_addr, mem_wr_data, seg_load, seg_addr, const_count, full
    );
endinterface

// File: rtl/statseg_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;  // 1 when requester 1 won the most recent grant

    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    assign last_d = (en_i && (req_i != 2'b00)) ? gnt_o[1] : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/statseg_ctrl.sv
// statseg_ctrl: writes declared constants to the static segment, loads statseg with each program's base
// and serves base+offset lookups. Define STATSEG_CTRL_BOUNDS_EN to compile in the err_oob offset check.
module statseg_ctrl
    import statseg_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                OFF_W     = DEF_OFF_W,
    parameter logic [ADDR_W-1:0] SEG_START = ADDR_W'(DEF_SEG_START),
    parameter int                SEG_LIMIT = 256
) (
    input logic           clk,
    input logic           reset,
    statseg_ctrl_if.slave bus
);
    localparam int                CW      = OFF_W + 1;
    localparam logic [ADDR_W-1:0] SEG_END = SEG_START + ADDR_W'(SEG_LIMIT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [ADDR_W-1:0] la_q, la_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              first_q, first_d;
    logic              idle, full_w, pend_eff, decl_acc, lkup_acc, wr_done, oob_w;
    logic [1:0]        gnt;

    assign idle     = (state_q == IDLE);
    assign full_w   = (wr_ptr_q == SEG_END);
    assign pend_eff = pend_q | bus.prog_start;
    assign decl_acc = idle & gnt[0];
    assign lkup_acc = idle & gnt[1];
    assign wr_done  = (state_q == WRITE) & bus.mem_wr_ack;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (idle),
        .req_i ({bus.lkup_valid, bus.decl_valid & ~full_w}),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (decl_acc)      state_d = WRITE;
                else if (lkup_acc) state_d = RESP;
            end
            WRITE:   if (bus.mem_wr_ack) state_d = first_q ? LOAD : IDLE;
            LOAD:    state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.decl_ready = 1'b0;
        bus.lkup_ready = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.seg_load   = 1'b0;
        bus.lkup_done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.decl_ready = gnt[0];
                bus.lkup_ready = gnt[1];
            end
            WRITE:   bus.mem_wr_en = 1'b1;
            LOAD:    bus.seg_load  = 1'b1;
            RESP:    bus.lkup_done = 1'b1;
            default: ;
        endcase
    end

    // A pending program start is folded in while idle, ahead of any declaration granted that cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        la_d     = la_q;
        cnt_d    = cnt_q;
        pend_d   = pend_eff;
        first_d  = first_q;
        if (idle && pend_eff) begin
            cnt_d   = '0;
            first_d = 1'b1;
            pend_d  = 1'b0;
        end
        if (decl_acc) begin
            wa_d = wr_ptr_q;
            wd_d = bus.decl_data;
        end
        if (lkup_acc) la_d = bus.seg_base + ADDR_W'(bus.lkup_off);
        if (wr_done) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            cnt_d    = cnt_q + CW'(1);
            first_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= SEG_START;
            wa_q     <= '0;
            wd_q     <= '0;
            la_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b1;
            first_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            la_q     <= la_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            first_q  <= first_d;
        end
    end

`ifdef STATSEG_CTRL_BOUNDS_EN
    logic          oob_q;
    logic [CW-1:0] cnt_eff;

    assign cnt_eff = pend_eff ? '0 : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         oob_q <= 1'b0;
        else if (lkup_acc) oob_q <= ({1'b0, bus.lkup_off} >= cnt_eff);
    end
    assign oob_w = oob_q;
`else
    assign oob_w = 1'b0;
`endif

    assign bus.err_oob     = bus.lkup_done & oob_w;
    assign bus.lkup_addr   = la_q;
    assign bus.mem_wr_addr = wa_q;
    assign bus.mem_wr_data = wd_q;
    assign bus.seg_addr    = (state_q == LOAD) ? wa_q : '0;
    assign bus.const_count = cnt_q;
    assign bus.full        = full_w;
endmodule

// File: tb/tb_statseg_ctrl.sv
// Self-checking bench for statseg_ctrl: directed scenarios plus randomized traffic against a program-level model.
module tb_statseg_ctrl;
    localparam int         AW    = 20;
    localparam int         DW    = 20;
    localparam int         OW    = 8;
    localparam int         LIMIT = 4;
    localparam logic [19:0] START = 20'h80000;
`ifdef STATSEG_CTRL_BOUNDS_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    statseg_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .OFF_W(OW)) bus ();

    statseg_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .OFF_W(OW), .SEG_START(START), .SEG_LIMIT(LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // program-level model: constants written so far, constants in current program, next decl is first
    int m_ptr, m_cnt;
    bit m_first;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic apply_reset();
        reset = 1'b1;
        bus.prog_start = 1'b0; bus.decl_valid = 1'b0; bus.lkup_valid = 1'b0;
        bus.mem_wr_ack = 1'b0; bus.decl_data = '0; bus.lkup_off = '0; bus.seg_base = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ptr = 0; m_cnt = 0; m_first = 1'b1;
    endtask

    task automatic pulse_prog();
        bus.prog_start = 1'b1;
        @(posedge clk); #1 bus.prog_start = 1'b0;
        @(posedge clk); #1;
        m_cnt = 0; m_first = 1'b1;
    endtask

    task automatic drive_decl(input logic [19:0] d, input int dly,
                              output logic wen, output logic [19:0] wa, output logic [19:0] wd,
                              output logic hold_ok, output logic ld, output logic [19:0] la,
                              output bit to);
        int n;
        to = 1'b0; hold_ok = 1'b1; wen = 1'b0; wa = '0; wd = '0; ld = 1'b0; la = '0; n = 0;
        bus.decl_valid = 1'b1; bus.decl_data = d;
        @(negedge clk);
        while (!bus.decl_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.decl_ready) begin
            to = 1'b1; bus.decl_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 bus.decl_valid = 1'b0;
        @(negedge clk);
        wen = bus.mem_wr_en; wa = bus.mem_wr_addr; wd = bus.mem_wr_data;
        repeat (dly) begin
            @(negedge clk);
            if (!bus.mem_wr_en || bus.mem_wr_addr !== wa || bus.mem_wr_data !== wd) hold_ok = 1'b0;
        end
        bus.mem_wr_ack = 1'b1;
        @(posedge clk); #1 bus.mem_wr_ack = 1'b0;
        @(negedge clk);
        ld = bus.seg_load; la = bus.seg_addr;
        @(posedge clk); #1;
    endtask

    task automatic drive_lkup(input logic [19:0] base, input logic [7:0] off,
                              output logic done, output logic oob, output logic [19:0] addr,
                              output logic done_after, output bit to);
        int n;
        to = 1'b0; done = 1'b0; oob = 1'b0; addr = '0; done_after = 1'b0; n = 0;
        bus.seg_base = base; bus.lkup_off = off; bus.lkup_valid = 1'b1;
        @(negedge clk);
        while (!bus.lkup_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.lkup_ready) begin
            to = 1'b1; bus.lkup_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 bus.lkup_valid = 1'b0;
        @(negedge clk);
        done = bus.lkup_done; oob = bus.err_oob; addr = bus.lkup_addr;
        @(negedge clk);
        done_after = bus.lkup_done;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({bus.mem_wr_en, bus.seg_load, bus.lkup_done, bus.err_oob, bus.decl_ready, bus.lkup_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {bus.mem_wr_en, bus.seg_load, bus.lkup_done, bus.err_oob, bus.decl_ready, bus.lkup_ready});
        end
        checks++;
        if ({bus.lkup_addr, bus.seg_addr, bus.mem_wr_addr, bus.mem_wr_data} !== 80'h0) begin
            failures++;
            $display("FAIL reset_buses: got %h expected 0", {bus.lkup_addr, bus.seg_addr, bus.mem_wr_addr, bus.mem_wr_data});
        end
        checks++;
        if (bus.const_count !== 9'd0 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL reset_count_full: count=%0d full=%b expected 0/0", bus.const_count, bus.full);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decl_seq();
        logic [19:0] data [3];
        logic wen, hold, ld; logic [19:0] wa, wd, la; bit to;
        data[0] = 20'h00AAA; data[1] = 20'h00BBB; data[2] = 20'h00CCC;
        pulse_prog();
        for (int i = 0; i < 3; i++) begin
            drive_decl(data[i], 2, wen, wa, wd, hold, ld, la, to);
            checks++;
            if (to) begin
                failures++; $display("FAIL decl_timeout[%0d]: ready never seen", i);
            end else if (wen !== 1'b1 || wa !== START + 20'(m_ptr) || wd !== data[i] || hold !== 1'b1) begin
                failures++;
                $display("FAIL decl_write[%0d]: en=%b addr=%h data=%h hold=%b expected 1/%h/%h/1",
                         i, wen, wa, wd, hold, START + 20'(m_ptr), data[i]);
            end
            checks++;
            if (ld !== m_first || (m_first && la !== START + 20'(m_ptr))) begin
                failures++;
                $display("FAIL decl_seg_load[%0d]: load=%b addr=%h expected %b/%h", i, ld, la, m_first, START + 20'(m_ptr));
            end
            m_ptr++; m_cnt++; m_first = 1'b0;
        end
        checks++;
        if (bus.const_count !== 9'(m_cnt)) begin
            failures++; $display("FAIL decl_count: got %0d expected %0d", bus.const_count, m_cnt);
        end
    endtask

    task automatic test_lookup();
        logic [19:0] base [3]; logic [7:0] off [3];
        logic done, oob, da; logic [19:0] addr, exp; bit to;
        base[0] = 20'h80000; off[0] = 8'd2;
        base[1] = 20'h80000; off[1] = 8'd3;
        base[2] = 20'hFFFFF; off[2] = 8'd5;
        for (int i = 0; i < 3; i++) begin
            drive_lkup(base[i], off[i], done, oob, addr, da, to);
            exp = 20'((32'(base[i]) + 32'(off[i])) % 32'h100000);
            checks++;
            if (to || done !== 1'b1 || da !== 1'b0 || addr !== exp) begin
                failures++;
                $display("FAIL lookup[%0d]: to=%b done=%b next=%b addr=%h expected 0/1/0/%h", i, to, done, da, addr, exp);
            end
            checks++;
            if (oob !== (OOB_EN && (int'(off[i]) >= m_cnt))) begin
                failures++;
                $display("FAIL lookup_oob[%0d]: got %b expected %b", i, oob, OOB_EN && (int'(off[i]) >= m_cnt));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq; int ng, n;
        apply_reset();
        seq = '0; ng = 0; n = 0;
        bus.decl_valid = 1'b1; bus.decl_data = 20'($urandom);
        bus.lkup_valid = 1'b1; bus.lkup_off = 8'd1; bus.seg_base = 20'($urandom);
        while (ng < 4 && n < 60) begin
            @(negedge clk);
            n++;
            bus.mem_wr_ack = bus.mem_wr_en;
            if (bus.decl_ready || bus.lkup_ready) begin
                seq = {seq[2:0], bus.decl_ready};
                ng++;
            end
        end
        @(posedge clk); #1;
        bus.decl_valid = 1'b0; bus.lkup_valid = 1'b0; bus.mem_wr_ack = 1'b0;
        repeat (4) @(posedge clk); #1;
        m_ptr = 2; m_cnt = 2; m_first = 1'b0;
        checks++;
        if (ng != 4 || seq !== 4'b1010) begin
            failures++; $display("FAIL rr_alternate: grants=%0d seq=%b expected 4/1010 (1=decl)", ng, seq);
        end
        checks++;
        if (bus.const_count !== 9'd2) begin
            failures++; $display("FAIL rr_count: got %0d expected 2", bus.const_count);
        end
    endtask

    task automatic test_full();
        logic wen, hold, ld, done, oob, da, seen; logic [19:0] wa, wd, la, addr; bit to;
        apply_reset();
        for (int i = 0; i < LIMIT; i++) begin
            drive_decl(20'($urandom), 0, wen, wa, wd, hold, ld, la, to);
            checks++;
            if (to || wa !== START + 20'(i) || bus.full !== (i == LIMIT - 1)) begin
                failures++;
                $display("FAIL full_fill[%0d]: to=%b addr=%h full=%b expected 0/%h/%b", i, to, wa, bus.full, START + 20'(i), i == LIMIT - 1);
            end
        end
        m_ptr = LIMIT; m_cnt = LIMIT; m_first = 1'b0;
        bus.decl_valid = 1'b1; bus.decl_data = 20'h12345;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (bus.decl_ready || bus.mem_wr_en) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL full_stall: decl accepted while full (seen=%b expected 0)", seen);
        end
        @(posedge clk); #1;
        drive_lkup(20'h80000, 8'd1, done, oob, addr, da, to);
        checks++;
        if (to || done !== 1'b1 || addr !== 20'h80001) begin
            failures++; $display("FAIL full_lookup: to=%b done=%b addr=%h expected 0/1/80001", to, done, addr);
        end
        bus.decl_valid = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.const_count !== 9'(LIMIT)) begin
            failures++; $display("FAIL full_hold: full=%b count=%0d expected 1/%0d", bus.full, bus.const_count, LIMIT);
        end
    endtask

    task automatic test_reset_mid_write();
        logic wen, hold, ld; logic [19:0] wa, wd, la; bit to; int n;
        apply_reset();
        drive_decl(20'h00111, 0, wen, wa, wd, hold, ld, la, to);
        bus.decl_valid = 1'b1; bus.decl_data = 20'h00222; n = 0;
        @(negedge clk);
        while (!bus.decl_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.decl_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (to || bus.mem_wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_write_drop: mem_wr_en=%b to=%b expected 0/0", bus.mem_wr_en, to);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ptr = 0; m_cnt = 0; m_first = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.const_count !== 9'd0 || bus.full !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_state: count=%0d full=%b en=%b expected 0/0/0", bus.const_count, bus.full, bus.mem_wr_en);
        end
        @(posedge clk); #1;
        drive_decl(20'h00333, 1, wen, wa, wd, hold, ld, la, to);
        checks++;
        if (to || wa !== START || ld !== 1'b1 || la !== START) begin
            failures++; $display("FAIL rst_restart: to=%b addr=%h load=%b seg=%h expected 0/%h/1/%h", to, wa, ld, la, START, START);
        end
        m_ptr = 1; m_cnt = 1; m_first = 1'b0;
    endtask

    task automatic test_random();
        logic wen, hold, ld, done, oob, da; logic [19:0] wa, wd, la, addr, d, base, exp;
        logic [7:0] off; bit to; int r;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_prog();
            end else if (r == 1) begin
                if (m_ptr == LIMIT) apply_reset();
            end else if (r <= 5) begin
                if (m_ptr == LIMIT) begin
                    checks++;
                    if (bus.full !== 1'b1) begin
                        failures++; $display("FAIL rnd_full[%0d]: got %b expected 1", it, bus.full);
                    end
                end else begin
                    d = 20'($urandom);
                    drive_decl(d, $urandom_range(0, 3), wen, wa, wd, hold, ld, la, to);
                    checks++;
                    if (to || wen !== 1'b1 || hold !== 1'b1 || wa !== START + 20'(m_ptr) || wd !== d ||
                        ld !== m_first || (m_first && la !== wa)) begin
                        failures++;
                        $display("FAIL rnd_decl[%0d]: to=%b en=%b hold=%b addr=%h data=%h load=%b seg=%h expected addr=%h data=%h load=%b",
                                 it, to, wen, hold, wa, wd, ld, la, START + 20'(m_ptr), d, m_first);
                    end
                    m_ptr++; m_cnt++; m_first = 1'b0;
                    checks++;
                    if (bus.const_count !== 9'(m_cnt)) begin
                        failures++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", it, bus.const_count, m_cnt);
                    end
                end
            end else begin
                base = 20'($urandom);
                off = 8'($urandom_range(0, 5));
                drive_lkup(base, off, done, oob, addr, da, to);
                exp = 20'((32'(base) + 32'(off)) % 32'h100000);
                checks++;
                if (to || done !== 1'b1 || da !== 1'b0 || addr !== exp ||
                    oob !== (OOB_EN && (int'(off) >= m_cnt))) begin
                    failures++;
                    $display("FAIL rnd_lkup[%0d]: to=%b done=%b next=%b addr=%h oob=%b expected addr=%h oob=%b",
                             it, to, done, da, addr, oob, exp, OOB_EN && (int'(off) >= m_cnt));
                end
            end
        end
    endtask

    initial begin
        bus.prog_start = 1'b0; bus.decl_valid = 1'b0; bus.lkup_valid = 1'b0;
        bus.mem_wr_ack = 1'b0; bus.decl_data = '0; bus.lkup_off = '0; bus.seg_base = '0;
        test_reset();
        test_decl_seq();
        test_lookup();
        test_back_to_back();
        test_full();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/statseg_ctrl.md
# statseg_ctrl

Controller for the static-segment base register (`statseg`) and the constant area it points to. Accepts constant declarations from the program loader, writes each to memory at a sequential address, and loads `statseg` with the address of a program's first constant. Serves base+offset address lookups from other units, sharing its single-issue engine with declarations through a 2-way round-robin arbiter. Sits between the loader/decoder, data memory and the `statseg` register.

## Interface
- `ADDR_W`, 20, address width (matches `statseg`)
- `DATA_W`, 20, constant data width
- `OFF_W`, 8, lookup offset width
- `SEG_START`, 20'h80000, first address of constant area
- `SEG_LIMIT`, 256, total constants storable before full

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `prog_start` in 1: pulse; the next declared constant becomes the new program's base
- `decl_valid` in 1 / `decl_ready` out 1 / `decl_data` in DATA_W: declaration handshake
- `lkup_valid` in 1 / `lkup_ready` out 1 / `lkup_off` in OFF_W: lookup request
- `lkup_addr` out ADDR_W / `lkup_done` out 1: lookup result and 1-cycle strobe
- `err_oob` out 1: 1-cycle strobe with `lkup_done` when offset ≥ program constant count
- `mem_wr_en` out 1 / `mem_wr_addr` out ADDR_W / `mem_wr_data` out DATA_W / `mem_wr_ack` in 1: memory write
- `seg_load` out 1 / `seg_addr` out ADDR_W: drive `statseg` load signal and data input
- `seg_base` in ADDR_W: `statseg` output, fed back
- `const_count` out OFF_W+1: constants declared in the current program
- `full` out 1: `wr_ptr == SEG_START + SEG_LIMIT`

## Operation
- FSM states: IDLE, WRITE, LOAD, RESP.
- IDLE: arbitrate. A request is granted when valid and its ready is high. Declarations are eligible only when `!full`. If both are eligible, grant the requester not granted last. `last_grant` resets to lookup, so declaration wins the first tie.
- `decl_ready` = IDLE & !full & (grant = decl). `lkup_ready` = IDLE & (grant = lkup). Both are 0 in every other state.
- Declaration accept: latch `decl_data` and `wr_ptr`, go to WRITE.
- WRITE: hold `mem_wr_en`=1 and stable addr/data until `mem_wr_ack` is sampled high. On ack: `wr_ptr`++, `const_count`++. Go to LOAD if this was the first constant of the program, else IDLE.
- LOAD: `seg_load`=1 and `seg_addr` = the written address, for exactly one cycle, then IDLE.
- Lookup accept: compute `lkup_addr` = `seg_base` + zero-extended `lkup_off`, modulo 2^ADDR_W, and register it. Go to RESP.
- RESP: `lkup_done`=1 for one cycle, then IDLE.
- `prog_start` sets a `pending_new` flag in any state. In IDLE the flag clears `const_count` and marks the next declaration as first. If it coincides with a declaration accept, it applies before that declaration.
- `wr_ptr` never wraps. It is restored to SEG_START only by reset. While full, declarations stall and lookups continue.

## Timing
- Reset values: all strobes/enables 0; `lkup_addr`, `seg_addr`, `mem_wr_*` 0; `const_count` 0; `wr_ptr` SEG_START; `pending_new` 1; state IDLE.
- Declaration latency: accept at T, `mem_wr_en` from T+1. With ack at cycle A, `seg_load` (first constant only) at A+1, and ready again at A+1 or A+2.
- Lookup latency: accept at T, `lkup_done` at T+1, ready at T+2.
- `mem_wr_ack` is ignored outside WRITE.
- Reset mid-WRITE: `mem_wr_en` drops asynchronously and the write is abandoned. Memory contents are undefined for that address.

## Configuration
- `STATSEG_CTRL_BOUNDS_EN` defined: the `err_oob` check is compiled in. `lkup_addr` is still produced on an error.
- Not defined: `err_oob` is tied to 0 and the comparison logic is absent.

## Structure
- `statseg_pkg` holds the FSM state enum, the default `ADDR_W`/`DATA_W`/`OFF_W`, and the `SEG_START` constant.
- Sub-module `rr_arb2` is a 2-request round-robin arbiter holding `last_grant`.

## Test plan
- Reset → all outputs at reset values, state IDLE, first declaration targets 0x80000.
- `prog_start`, then declare 0x00AAA, 0x00BBB, 0x00CCC with ack 2 cycles after `mem_wr_en` → writes at 0x80000/1/2; one `seg_load` with `seg_addr`=0x80000; `const_count`=3.
- `seg_base`=0x80000, lookup off 2 → `lkup_addr`=0x80002 with `lkup_done` one cycle after accept. Off 3 → `err_oob`=1 (macro defined), 0 (undefined).
- Both requesters valid continuously → grants alternate decl, lkup, decl, lkup.
- `SEG_LIMIT`=4, declare 5 → `full` after the 4th ack, `decl_ready` stays 0; a lookup is still served.
- Assert `reset` two cycles into WRITE → `mem_wr_en` 0 immediately; after release, state IDLE and `wr_ptr`=0x80000.
